// File: rtl/seq_squarer_if.sv
// Streaming handshake bundle for seq_squarer: an operand channel in and a result channel out.
// Both channels transfer on a rising clock edge where valid and ready are both high.
interface seq_squarer_if #(
  parameter int WIDTH = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/seq_squarer.sv
// Iterative squarer: takes |x| on accept, then adds one shifted partial product per clock
// for WIDTH clocks and presents x*x in 2*WIDTH bits until the consumer takes it.
module seq_squarer #(
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_squarer_if.slave sq_if,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   out_data_q, out_data_d;

  logic                 neg_in;
  logic [WIDTH-1:0]     abs_in;
  logic [WIDTH-1:0]     mag_shr;
  logic                 mag_bit;
  logic [2*WIDTH-1:0]   step_sum;

  // The most negative operand negates to itself in WIDTH bits, which read unsigned is its magnitude.
  assign neg_in  = sq_if.in_signed & sq_if.in_data[WIDTH-1];
  assign abs_in  = neg_in ? (~sq_if.in_data + WIDTH'(1)) : sq_if.in_data;

  assign mag_shr  = mag_q >> cnt_q;
  assign mag_bit  = mag_shr[0];
  assign step_sum = acc_q + (mag_bit ? (mcand_q << cnt_q) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;

    case (state_q)
      IDLE: begin
        if (sq_if.in_valid) begin
          mag_d   = abs_in;
          mcand_d = {{WIDTH{1'b0}}, abs_in};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = step_sum;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          out_data_d = step_sum;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (sq_if.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake: each channel transfers on a rising edge where its valid and ready are both 1;
  // in_ready and out_valid are pure decodes of the registered state.
  assign sq_if.in_ready  = (state_q == IDLE);
  assign sq_if.out_valid = (state_q == DONE);
  assign sq_if.out_data  = out_data_q;
  assign state_o         = state_q;

  a_result_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DONE && !sq_if.out_ready) |=> (state_q == DONE && $stable(out_data_q)));

  a_channels_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(sq_if.in_ready && sq_if.out_valid));

endmodule

// File: tb/tb_seq_squarer.sv
// Bench for seq_squarer: vector table, hand-written protocol/reset sequences and a randomized
// sweep at WIDTH 5, 8 and 16 against an arithmetic reference model.
module tb_seq_squarer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  seq_squarer_if #(.WIDTH(5))  if5();
  seq_squarer_if #(.WIDTH(8))  if8();
  seq_squarer_if #(.WIDTH(16)) if16();
  logic [1:0] st5, st8, st16;

  seq_squarer #(.WIDTH(5))  dut5  (.clk(clk), .rst_n(rst_n), .sq_if(if5.slave),  .state_o(st5));
  seq_squarer #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .sq_if(if8.slave),  .state_o(st8));
  seq_squarer #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .sq_if(if16.slave), .state_o(st16));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    if5.in_valid = 0;  if5.in_data = '0;  if5.in_signed = 0;  if5.out_ready = 1;
    if8.in_valid = 0;  if8.in_data = '0;  if8.in_signed = 0;  if8.out_ready = 1;
    if16.in_valid = 0; if16.in_data = '0; if16.in_signed = 0; if16.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Square of the operand as the spec defines it: signed reinterpretation, then plain multiply.
  function automatic longint sq_ref(input longint d, input int w, input bit s);
    longint v;
    v = (s && ((d >> (w - 1)) & 1) != 0) ? d - (longint'(1) << w) : d;
    return (v * v) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // ---------------- drivers ----------------
  task automatic transact5(input logic [4:0] d, input logic s, output logic [9:0] res, output int lat);
    @(negedge clk);
    check("in_ready_before_accept5", if5.in_ready, 1);
    if5.in_valid = 1; if5.in_data = d; if5.in_signed = s;
    @(posedge clk); #1;
    if5.in_valid = 0; if5.in_data = 5'($urandom); if5.in_signed = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!if5.out_valid && lat < 40);
    res = if5.out_data;
    if (if5.out_ready) begin
      @(posedge clk); #1;
      check("in_ready_after_hs5", if5.in_ready, 1);
    end
  endtask

  task automatic transact8(input logic [7:0] d, input logic s, output logic [15:0] res, output int lat);
    @(negedge clk);
    if8.in_valid = 1; if8.in_data = d; if8.in_signed = s;
    @(posedge clk); #1;
    if8.in_valid = 0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!if8.out_valid && lat < 60);
    res = if8.out_data;
    @(posedge clk); #1;
  endtask

  task automatic transact16(input logic [15:0] d, input logic s, output logic [31:0] res, output int lat);
    @(negedge clk);
    if16.in_valid = 1; if16.in_data = d; if16.in_signed = s;
    @(posedge clk); #1;
    if16.in_valid = 0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!if16.out_valid && lat < 100);
    res = if16.out_data;
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] d;
    logic       s;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [9:0]  r5;
    logic [15:0] r8;
    logic [31:0] r16;
    int          lat;
    logic [4:0]  ops[21];

    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{5'h1F,     1'b0, 10'd961};
    vecs[1] = '{5'b10000,  1'b1, 10'd256};
    vecs[2] = '{5'b11111,  1'b1, 10'd1};
    vecs[3] = '{5'b01111,  1'b1, 10'd225};
    vecs[4] = '{5'd0,      1'b0, 10'd0};
    vecs[5] = '{5'd0,      1'b1, 10'd0};
    vecs[6] = '{5'd7,      1'b0, 10'd49};
    vecs[7] = '{5'b10000,  1'b0, 10'd256};

    do_reset();

    // reset state
    #1;
    check("reset_in_ready", if5.in_ready, 1);
    check("reset_out_valid", if5.out_valid, 0);
    check("reset_out_data", if5.out_data, 0);
    check("reset_state", st5, 0);

    // table
    for (int i = 0; i < 8; i++) begin
      transact5(vecs[i].d, vecs[i].s, r5, lat);
      check($sformatf("vec%0d_data", i), r5, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, 5);
    end

    // backpressure: result held for 12 cycles
    if5.out_ready = 0;
    transact5(5'd7, 1'b0, r5, lat);
    check("bp_latency", lat, 5);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", if5.out_valid, 1);
      check("bp_out_data", if5.out_data, 49);
      check("bp_in_ready", if5.in_ready, 0);
    end
    @(negedge clk);
    if5.out_ready = 1;
    @(posedge clk); #1;
    check("bp_release_out_valid", if5.out_valid, 0);
    check("bp_release_in_ready", if5.in_ready, 1);
    check("bp_data_kept", if5.out_data, 49);

    // in_valid held with changing data: accepts land at edges 0, 7, 14
    for (int e = 0; e < 21; e++) begin
      @(negedge clk);
      ops[e] = 5'((e * 3 + 1) % 32);
      if5.in_valid = 1; if5.in_data = ops[e]; if5.in_signed = 0;
      @(posedge clk); #1;
      check("stream_out_valid", if5.out_valid, (e % 7 == 5) ? 1 : 0);
      if (e % 7 == 5) begin
        check("stream_out_data", if5.out_data, sq_ref(longint'(ops[e - 5]), 5, 1'b0));
      end
    end
    if5.in_valid = 0;

    // reset in the middle of BUSY
    @(negedge clk);
    if5.in_valid = 1; if5.in_data = 5'h1F; if5.in_signed = 0;
    @(posedge clk); #1;
    if5.in_valid = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("midreset_out_valid", if5.out_valid, 0);
    check("midreset_in_ready", if5.in_ready, 1);
    check("midreset_state", st5, 0);
    check("midreset_out_data", if5.out_data, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (8) begin
      @(posedge clk); #1;
      check("midreset_no_stale_result", if5.out_valid, 0);
    end
    transact5(5'd3, 1'b0, r5, lat);
    check("after_reset_data", r5, 9);
    check("after_reset_latency", lat, 5);

    // exhaustive WIDTH=5, both modes
    for (int s = 0; s < 2; s++) begin
      for (int d = 0; d < 32; d++) begin
        exp_q.push_back(32'(sq_ref(longint'(d), 5, s[0])));
        transact5(5'(d), s[0], r5, lat);
        check($sformatf("sweep5_s%0d_d%0d", s, d), r5, exp_q.pop_front());
        check("sweep5_latency", lat, 5);
      end
    end

    // random WIDTH=8 and WIDTH=16
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d8;
      logic       s8;
      d8 = 8'($urandom_range(0, 255));
      s8 = 1'($urandom_range(0, 1));
      exp_q.push_back(32'(sq_ref(longint'(d8), 8, s8)));
      transact8(d8, s8, r8, lat);
      check("rand8_data", r8, exp_q.pop_front());
      check("rand8_latency", lat, 8);
    end
    for (int i = 0; i < 40; i++) begin
      logic [15:0] d16;
      logic        s16;
      d16 = 16'($urandom);
      s16 = 1'($urandom_range(0, 1));
      exp_q.push_back(32'(sq_ref(longint'(d16), 16, s16)));
      transact16(d16, s16, r16, lat);
      check("rand16_data", r16, exp_q.pop_front());
      check("rand16_latency", lat, 16);
    end
    transact16(16'h8000, 1'b1, r16, lat);
    check("w16_most_negative", r16, 32'h4000_0000);
    transact16(16'hFFFF, 1'b0, r16, lat);
    check("w16_unsigned_max", r16, 32'hFFFE_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends with a report.
  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
